// File: rtl/axi4_lite_mem_slave_p.sv
// AXI4-Lite memory slave with byte-lane writes, AW/W accepted in either order,
// SLVERR on out-of-range words and write-to-read bypass on same-edge collisions.
module axi4_lite_mem_slave_p #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4096,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [STRB_WIDTH-1:0] WSTRB,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RVALID,
    input  logic                  RREADY
);
    localparam int ADDR_LSB = $clog2(STRB_WIDTH);
    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A     = ADDR_WIDTH'(DEPTH);
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_VALID} r_state_t;

    // ---------------- write channel ----------------
    w_state_t              w_state_reg, w_state_next;
    logic [ADDR_WIDTH-1:0] aw_addr_reg, aw_addr_next;
    logic [DATA_WIDTH-1:0] w_data_reg, w_data_next;
    logic [STRB_WIDTH-1:0] w_strb_reg, w_strb_next;
    logic [1:0]            bresp_reg, bresp_next;

    logic                  aw_hs, w_hs, commit, commit_in_range, mem_we;
    logic [ADDR_WIDTH-1:0] commit_addr, commit_word;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [STRB_WIDTH-1:0] commit_strb;
    logic [IDX_W-1:0]      commit_idx;

    assign AWREADY = (w_state_reg == W_IDLE) || (w_state_reg == W_HAVE_D);
    assign WREADY  = (w_state_reg == W_IDLE) || (w_state_reg == W_HAVE_A);
    assign BVALID  = (w_state_reg == W_RESP);
    assign BRESP   = bresp_reg;
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;

    always_comb begin
        w_state_next = w_state_reg;
        aw_addr_next = aw_addr_reg;
        w_data_next  = w_data_reg;
        w_strb_next  = w_strb_reg;
        bresp_next   = bresp_reg;
        commit       = 1'b0;
        commit_addr  = AWADDR;
        commit_data  = WDATA;
        commit_strb  = WSTRB;
        case (w_state_reg)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                end else if (aw_hs) begin
                    aw_addr_next = AWADDR;
                    w_state_next = W_HAVE_A;
                end else if (w_hs) begin
                    w_data_next  = WDATA;
                    w_strb_next  = WSTRB;
                    w_state_next = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                commit_addr = aw_addr_reg;
                commit      = w_hs;
            end
            W_HAVE_D: begin
                commit_data = w_data_reg;
                commit_strb = w_strb_reg;
                commit      = aw_hs;
            end
            W_RESP: begin
                if (BREADY) begin
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
        commit_word     = commit_addr >> ADDR_LSB;
        commit_in_range = (commit_word < DEPTH_A);
        commit_idx      = commit_word[IDX_W-1:0];
        if (commit) begin
            w_state_next = W_RESP;
            bresp_next   = commit_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // A commit landing on a reset edge is dropped along with the rest of the write.
    assign mem_we = commit && commit_in_range && !ARESET;

    // ---------------- read channel ----------------
    r_state_t              r_state_reg, r_state_next;
    logic [1:0]            rresp_reg, rresp_next;
    logic                  rd_zero_reg, rd_zero_next;
    logic [STRB_WIDTH-1:0] byp_strb_reg, byp_strb_next;
    logic [DATA_WIDTH-1:0] byp_data_reg, byp_data_next;

    logic                  ar_hs, ar_in_range, mem_re;
    logic [ADDR_WIDTH-1:0] ar_word;
    logic [IDX_W-1:0]      ar_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    assign ARREADY     = (r_state_reg == R_IDLE);
    assign RVALID      = (r_state_reg == R_VALID);
    assign RRESP       = rresp_reg;
    assign ar_hs       = ARVALID && ARREADY;
    assign ar_word     = ARADDR >> ADDR_LSB;
    assign ar_in_range = (ar_word < DEPTH_A);
    assign ar_idx      = ar_word[IDX_W-1:0];
    assign mem_re      = ar_hs && ar_in_range && !ARESET;

    always_comb begin
        r_state_next  = r_state_reg;
        rresp_next    = rresp_reg;
        rd_zero_next  = rd_zero_reg;
        byp_strb_next = byp_strb_reg;
        byp_data_next = byp_data_reg;
        case (r_state_reg)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_next  = R_VALID;
                    rresp_next    = ar_in_range ? RESP_OKAY : RESP_SLVERR;
                    rd_zero_next  = !ar_in_range;
                    // The memory read sees the old word; patch in the lanes written at this edge.
                    byp_strb_next = (mem_we && ar_in_range && (commit_idx == ar_idx))
                                    ? commit_strb : '0;
                    byp_data_next = commit_data;
                end
            end
            R_VALID: begin
                if (RREADY) begin
                    r_state_next = R_IDLE;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_reg  <= W_IDLE;
            bresp_reg    <= RESP_OKAY;
            r_state_reg  <= R_IDLE;
            rresp_reg    <= RESP_OKAY;
            rd_zero_reg  <= 1'b1;
            byp_strb_reg <= '0;
        end else begin
            w_state_reg  <= w_state_next;
            bresp_reg    <= bresp_next;
            r_state_reg  <= r_state_next;
            rresp_reg    <= rresp_next;
            rd_zero_reg  <= rd_zero_next;
            byp_strb_reg <= byp_strb_next;
        end
        aw_addr_reg  <= aw_addr_next;
        w_data_reg   <= w_data_next;
        w_strb_reg   <= w_strb_next;
        byp_data_reg <= byp_data_next;
    end

    // ---------------- byte-lane memories ----------------
    genvar gi;
    generate
        for (gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];
            logic [7:0] rd_lane_reg;

            always_ff @(posedge ACLK) begin
                if (mem_we && commit_strb[gi]) begin
                    mem_lane[commit_idx] <= commit_data[gi*8 +: 8];
                end
                if (mem_re) begin
                    rd_lane_reg <= mem_lane[ar_idx];
                end
            end

            assign rd_word[gi*8 +: 8] = byp_strb_reg[gi] ? byp_data_reg[gi*8 +: 8] : rd_lane_reg;
        end
    endgenerate

    assign RDATA = rd_zero_reg ? '0 : rd_word;

endmodule

// File: tb/tb_axi4_lite_mem_slave_p.sv
// Bench for axi4_lite_mem_slave_p: directed vector table, hand-built stall/reset
// sequences, then random traffic against a word-array reference model.
module tb_axi4_lite_mem_slave_p;
    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [31:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [31:0] ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;

    always #5 ACLK = ~ACLK;

    axi4_lite_mem_slave_p dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct {
        bit          do_w;
        bit          do_r;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [31:0] ra;
        int          aw_dly;
        int          w_dly;
        int          ar_dly;
        int          b_dly;
        int          r_dly;
    } txn_t;

    typedef struct {
        logic [1:0]  bresp;
        logic [1:0]  rresp;
        logic [31:0] rdata;
        int          b_lat;
        int          r_lat;
        bit          timeout;
        bit          stable;
    } res_t;

    typedef struct {
        txn_t        t;
        logic [1:0]  exp_b;
        logic [1:0]  exp_r;
        logic [31:0] exp_rd;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model [int];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return (a >> 2) < 32'd4096;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        logic [31:0] w;
        if (!in_range(a)) return;
        idx = int'(a >> 2);
        w = model.exists(idx) ? model[idx] : 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
        end
        model[idx] = w;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int idx;
        if (!in_range(a)) return 32'h0;
        idx = int'(a >> 2);
        return model.exists(idx) ? model[idx] : 32'h0;
    endfunction

    function automatic txn_t mk(input bit w, input bit r, input logic [31:0] wa, input logic [31:0] wd,
                                input logic [3:0] ws, input logic [31:0] ra,
                                input int awd, input int wdl, input int ard);
        txn_t t;
        t.do_w = w; t.do_r = r; t.wa = wa; t.wd = wd; t.ws = ws; t.ra = ra;
        t.aw_dly = awd; t.w_dly = wdl; t.ar_dly = ard; t.b_dly = 0; t.r_dly = 0;
        return t;
    endfunction

    function automatic vec_t mkv(input txn_t t, input logic [1:0] eb, input logic [1:0] er, input logic [31:0] erd);
        vec_t v;
        v.t = t; v.exp_b = eb; v.exp_r = er; v.exp_rd = erd;
        return v;
    endfunction

    // Starts and ends 1 time unit after a rising edge; every wait is bounded.
    task automatic run_txn(input txn_t t, output res_t r);
        bit aw_done, w_done, ar_done, b_done, r_done;
        bit aw_f, w_f, ar_f, b_f, r_f;
        int whs_cyc, ar_cyc, b_first, r_first, cyc;
        aw_done = !t.do_w; w_done = !t.do_w; b_done = !t.do_w;
        ar_done = !t.do_r; r_done = !t.do_r;
        whs_cyc = -1; ar_cyc = -1; b_first = -1; r_first = -1; cyc = 0;
        r.bresp = 'x; r.rresp = 'x; r.rdata = 'x; r.stable = 1'b1; r.b_lat = -1; r.r_lat = -1;
        AWADDR = t.wa; WDATA = t.wd; WSTRB = t.ws; ARADDR = t.ra;
        while (!(b_done && r_done) && cyc < 60) begin
            AWVALID = !aw_done && cyc >= t.aw_dly;
            WVALID  = !w_done && cyc >= t.w_dly;
            ARVALID = !ar_done && cyc >= t.ar_dly;
            if (BVALID && !b_done) begin
                if (b_first < 0) begin b_first = cyc; r.bresp = BRESP; end
                else if (BRESP !== r.bresp) r.stable = 1'b0;
            end
            if (RVALID && !r_done) begin
                if (r_first < 0) begin r_first = cyc; r.rresp = RRESP; r.rdata = RDATA; end
                else if (RDATA !== r.rdata || RRESP !== r.rresp) r.stable = 1'b0;
            end
            BREADY = BVALID && !b_done && (cyc - b_first >= t.b_dly);
            RREADY = RVALID && !r_done && (cyc - r_first >= t.r_dly);
            aw_f = AWVALID && AWREADY;
            w_f  = WVALID && WREADY;
            ar_f = ARVALID && ARREADY;
            b_f  = BVALID && BREADY;
            r_f  = RVALID && RREADY;
            @(posedge ACLK); #1;
            if (aw_f) aw_done = 1'b1;
            if (w_f) w_done = 1'b1;
            if ((aw_f || w_f) && aw_done && w_done && whs_cyc < 0) whs_cyc = cyc;
            if (ar_f) begin ar_done = 1'b1; ar_cyc = cyc; end
            if (b_f) b_done = 1'b1;
            if (r_f) r_done = 1'b1;
            cyc++;
        end
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0; BREADY = 1'b0; RREADY = 1'b0;
        r.timeout = !(b_done && r_done);
        if (b_first >= 0 && whs_cyc >= 0) r.b_lat = b_first - whs_cyc;
        if (r_first >= 0 && ar_cyc >= 0) r.r_lat = r_first - ar_cyc;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        res_t r;
        run_txn(v.t, r);
        chk({name, " done"}, r.timeout, 1'b0);
        if (v.t.do_w) begin
            chk({name, " bresp"}, r.bresp, v.exp_b);
            chk({name, " b_latency"}, r.b_lat, 1);
        end
        if (v.t.do_r) begin
            chk({name, " rresp"}, r.rresp, v.exp_r);
            chk({name, " rdata"}, r.rdata, v.exp_rd);
            chk({name, " r_latency"}, r.r_lat, 1);
        end
        chk({name, " stable"}, r.stable, 1'b1);
        $display("txn %s: w=%0b r=%0b wa=%h wd=%h ws=%h ra=%h -> bresp=%0d rresp=%0d rdata=%h",
                 name, v.t.do_w, v.t.do_r, v.t.wa, v.t.wd, v.t.ws, v.t.ra, r.bresp, r.rresp, r.rdata);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0) return 32'h4000 + 32'($urandom_range(0, 1023)) * 4;
            return $urandom | 32'h8000_0000;
        end
        return 32'h80 + 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        vec_t post[$];
        txn_t t;
        res_t r;
        logic [31:0] exp_rd;
        bit read_first;
        int mx;

        // -------- reset state --------
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        chk("reset flags {awr,wr,arr,bv,rv}", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b11100);
        chk("reset bresp", BRESP, 2'b00);
        chk("reset rresp", RRESP, 2'b00);
        chk("reset rdata", RDATA, 32'h0);

        // -------- directed vector table --------
        vecs.push_back(mkv(mk(1, 0, 32'h444, 32'h11223344, 4'hF, 0, 0, 0, 0), 2'b00, 2'b00, 0));
        vecs.push_back(mkv(mk(0, 1, 0, 0, 0, 32'h444, 0, 0, 0), 2'b00, 2'b00, 32'h11223344));
        vecs.push_back(mkv(mk(1, 0, 32'h8, 32'h0, 4'hF, 0, 0, 0, 0), 2'b00, 2'b00, 0));
        vecs.push_back(mkv(mk(1, 0, 32'h8, 32'hAABBCCDD, 4'h5, 0, 3, 0, 0), 2'b00, 2'b00, 0));
        vecs.push_back(mkv(mk(0, 1, 0, 0, 0, 32'h8, 0, 0, 0), 2'b00, 2'b00, 32'h00BB00DD));
        vecs.push_back(mkv(mk(1, 0, 32'h2AA8, 32'h01020304, 4'hF, 0, 0, 0, 0), 2'b00, 2'b00, 0));
        vecs.push_back(mkv(mk(1, 0, 32'hAAAAAAA, 32'h068F48F4, 4'hF, 0, 0, 0, 0), 2'b10, 2'b00, 0));
        vecs.push_back(mkv(mk(0, 1, 0, 0, 0, 32'hAAAAAAA, 0, 0, 0), 2'b00, 2'b10, 32'h0));
        vecs.push_back(mkv(mk(0, 1, 0, 0, 0, 32'h2AA8, 0, 0, 0), 2'b00, 2'b00, 32'h01020304));
        vecs.push_back(mkv(mk(1, 0, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0), 2'b00, 2'b00, 0));
        vecs.push_back(mkv(mk(1, 1, 32'h1000, 32'h00000001, 4'hF, 32'h1000, 0, 0, 0), 2'b00, 2'b00, 32'h00000001));
        vecs.push_back(mkv(mk(1, 1, 32'h1000, 32'h0000AB00, 4'h2, 32'h1000, 0, 0, 0), 2'b00, 2'b00, 32'h0000AB01));
        vecs.push_back(mkv(mk(1, 0, 32'h3FFC, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0), 2'b00, 2'b00, 0));
        vecs.push_back(mkv(mk(0, 1, 0, 0, 0, 32'h3FFC, 0, 0, 0), 2'b00, 2'b00, 32'hCAFEF00D));
        vecs.push_back(mkv(mk(1, 0, 32'h4000, 32'h12345678, 4'hF, 0, 0, 0, 0), 2'b10, 2'b00, 0));
        vecs.push_back(mkv(mk(0, 1, 0, 0, 0, 32'h4000, 0, 0, 0), 2'b00, 2'b10, 32'h0));
        vecs.push_back(mkv(mk(0, 1, 0, 0, 0, 32'h0, 0, 0, 0), 2'b00, 2'b00, 32'h0));
        vecs.push_back(mkv(mk(0, 1, 0, 0, 0, 32'h446, 0, 0, 0), 2'b00, 2'b00, 32'h11223344));
        vecs.push_back(mkv(mk(1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0), 2'b00, 2'b00, 0));
        vecs.push_back(mkv(mk(1, 0, 32'h10, 32'h00000000, 4'h0, 0, 0, 0, 0), 2'b00, 2'b00, 0));
        vecs.push_back(mkv(mk(0, 1, 0, 0, 0, 32'h10, 0, 0, 0), 2'b00, 2'b00, 32'hDEADBEEF));
        vecs.push_back(mkv(mk(1, 0, 32'h12, 32'h00001234, 4'h3, 0, 0, 0, 0), 2'b00, 2'b00, 0));
        vecs.push_back(mkv(mk(0, 1, 0, 0, 0, 32'h10, 0, 0, 0), 2'b00, 2'b00, 32'hDEAD1234));
        vecs.push_back(mkv(mk(1, 1, 32'h10, 32'h11111111, 4'hF, 32'h10, 1, 2, 0), 2'b00, 2'b00, 32'hDEAD1234));
        vecs.push_back(mkv(mk(0, 1, 0, 0, 0, 32'h10, 0, 0, 0), 2'b00, 2'b00, 32'h11111111));
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // -------- stalled responses: BREADY/RREADY low for 10 cycles --------
        AWADDR = 32'h20; WDATA = 32'h55; WSTRB = 4'hF; ARADDR = 32'h444;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("hold%0d flags {bv,rv,awr,wr,arr}", c), {BVALID, RVALID, AWREADY, WREADY, ARREADY}, 5'b11000);
            chk($sformatf("hold%0d rdata", c), RDATA, 32'h11223344);
            chk($sformatf("hold%0d resp {b,r}", c), {BRESP, RRESP}, 4'b0000);
            @(posedge ACLK); #1;
        end
        BREADY = 1'b1; RREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0; RREADY = 1'b0;
        chk("hold release flags {bv,rv,awr,wr,arr}", {BVALID, RVALID, AWREADY, WREADY, ARREADY}, 5'b00111);
        $display("txn hold: write 0x20=0x55 and read 0x444 stalled 10 cycles then released");

        // -------- reset while holding only an address --------
        AWADDR = 32'h20; WDATA = 32'h0; AWVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        chk("have_a ready {awr,wr}", {AWREADY, WREADY}, 2'b01);
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        chk("mid-reset flags {awr,wr,arr,bv,rv}", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b11100);
        chk("mid-reset rdata", RDATA, 32'h0);
        repeat (3) @(posedge ACLK);
        #1 chk("mid-reset no bvalid", BVALID, 1'b0);
        $display("txn reset: ARESET pulsed with address 0x20 captured");
        post.push_back(mkv(mk(0, 1, 0, 0, 0, 32'h20, 0, 0, 0), 2'b00, 2'b00, 32'h00000055));
        post.push_back(mkv(mk(0, 1, 0, 0, 0, 32'h444, 0, 0, 0), 2'b00, 2'b00, 32'h11223344));
        post.push_back(mkv(mk(1, 0, 32'h24, 32'h00000077, 4'hF, 0, 0, 0, 0), 2'b00, 2'b00, 0));
        post.push_back(mkv(mk(0, 1, 0, 0, 0, 32'h24, 0, 0, 0), 2'b00, 2'b00, 32'h00000077));
        post.push_back(mkv(mk(0, 1, 0, 0, 0, 32'h20, 0, 0, 0), 2'b00, 2'b00, 32'h00000055));
        for (int i = 0; i < post.size(); i++) begin
            run_vec($sformatf("post%0d", i), post[i]);
        end

        // -------- random traffic against the reference model --------
        for (int i = 0; i < 32; i++) begin
            t = mk(1, 0, 32'h80 + 32'(i) * 4, $urandom, 4'hF, 0, 0, 0, 0);
            model_write(t.wa, t.wd, t.ws);
            run_vec($sformatf("init%0d", i), mkv(t, 2'b00, 2'b00, 0));
        end
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 2))
                0:       begin t.do_w = 1; t.do_r = 0; end
                1:       begin t.do_w = 0; t.do_r = 1; end
                default: begin t.do_w = 1; t.do_r = 1; end
            endcase
            t.wa = rand_addr();
            t.wd = $urandom;
            t.ws = 4'($urandom);
            t.ra = ($urandom_range(0, 1) == 1) ? t.wa : rand_addr();
            t.aw_dly = $urandom_range(0, 3);
            t.w_dly  = $urandom_range(0, 3);
            t.ar_dly = $urandom_range(0, 3);
            t.b_dly  = $urandom_range(0, 3);
            t.r_dly  = $urandom_range(0, 3);
            mx = (t.aw_dly > t.w_dly) ? t.aw_dly : t.w_dly;
            read_first = t.do_r && t.do_w && (t.ar_dly < mx);
            exp_rd = 32'h0;
            if (read_first) exp_rd = model_read(t.ra);
            if (t.do_w) model_write(t.wa, t.wd, t.ws);
            if (!read_first) exp_rd = model_read(t.ra);
            run_vec($sformatf("rnd%0d", i),
                    mkv(t, in_range(t.wa) ? 2'b00 : 2'b10, in_range(t.ra) ? 2'b00 : 2'b10, exp_rd));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
